// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_BUBBLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Drives program_counter inc/load and offers fetched instructions to the decoder
// over valid/ready, handling the post-load bubble, stalls, branches and halt/run.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_pc_instruction,
  input  logic [ADDR_WIDTH-1:0] i_pc_addr,
  output logic                  o_pc_inc,
  output logic                  o_pc_load,
  output logic [ADDR_WIDTH-1:0] o_pc_addr,
  output logic [15:0]           o_instruction,
  output logic [ADDR_WIDTH-1:0] o_instr_addr,
  output logic                  o_instr_valid,
  input  logic                  i_ready,
  input  logic                  i_branch,
  input  logic [ADDR_WIDTH-1:0] i_branch_addr,
  input  logic                  i_halt,
  input  logic                  i_run,
  output logic                  o_halted,
  output logic [15:0]           o_retired_count
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [15:0]             hold_instr_reg;
  logic [ADDR_WIDTH-1:0]   hold_addr_reg;
  logic [ADDR_WIDTH-1:0]   resume_addr_reg;
  logic [ADDR_WIDTH-1:0]   fetch_addr_reg;
  logic [15:0]             retired_count_reg;
  logic [ADDR_WIDTH-1:0]   halt_addr;
  logic                    transfer;

  assign transfer        = o_instr_valid & i_ready & ~i_branch;
  assign o_retired_count = retired_count_reg;
  assign o_instruction   = (state_reg == ST_HOLD) ? hold_instr_reg : i_pc_instruction;
  assign o_instr_addr    = (state_reg == ST_HOLD) ? hold_addr_reg  : i_pc_addr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT:   state_next = (i_halt && !i_branch) ? ST_HALTED : ST_BUBBLE;
      ST_BUBBLE: begin
        if (i_branch)    state_next = ST_BUBBLE;
        else if (i_halt) state_next = ST_HALTED;
        else             state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_branch)      state_next = ST_BUBBLE;
        else if (i_halt)   state_next = ST_HALTED;
        else if (!i_ready) state_next = ST_HOLD;
        else               state_next = ST_RUN;
      end
      ST_HOLD: begin
        if (i_branch)     state_next = ST_BUBBLE;
        else if (i_halt)  state_next = ST_HALTED;
        else if (i_ready) state_next = ST_BUBBLE;
        else              state_next = ST_HOLD;
      end
      ST_HALTED: begin
        if (i_run && !i_halt && !i_branch) state_next = ST_BUBBLE;
      end
      default:   state_next = ST_BOOT;
    endcase
  end

  // Outputs depend only on state and the control inputs, never on i_pc_*.
  always_comb begin
    o_pc_inc      = 1'b0;
    o_pc_load     = 1'b0;
    o_pc_addr     = RESET_VECTOR;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        o_pc_load = 1'b1;
        if (i_branch) o_pc_addr = i_branch_addr;
      end
      ST_BUBBLE: begin
        if (i_branch) begin
          o_pc_load = 1'b1;
          o_pc_addr = i_branch_addr;
        end else begin
          o_pc_inc = 1'b1;
        end
      end
      ST_RUN: begin
        o_instr_valid = 1'b1;
        if (i_branch) begin
          o_pc_load = 1'b1;
          o_pc_addr = i_branch_addr;
        end else begin
          o_pc_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_branch) begin
          o_pc_load = 1'b1;
          o_pc_addr = i_branch_addr;
        end else if (i_ready) begin
          o_pc_load = 1'b1;
          o_pc_addr = hold_addr_reg + ADDR_WIDTH'(1);
        end
      end
      ST_HALTED: begin
        o_halted = 1'b1;
        if (i_run && !i_halt && !i_branch) begin
          o_pc_load = 1'b1;
          o_pc_addr = resume_addr_reg;
        end
      end
      default: begin
        o_pc_load = 1'b1;
      end
    endcase
  end

  // Where execution picks up again after a halt taken in the current state.
  always_comb begin
    case (state_reg)
      ST_BOOT:   halt_addr = RESET_VECTOR;
      ST_BUBBLE: halt_addr = fetch_addr_reg;
      default:   halt_addr = o_instr_addr + (transfer ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0));
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hold_instr_reg    <= '0;
      hold_addr_reg     <= '0;
      resume_addr_reg   <= '0;
      fetch_addr_reg    <= RESET_VECTOR;
      retired_count_reg <= '0;
    end else begin
      if (transfer) retired_count_reg <= retired_count_reg + 16'd1;
      if (o_pc_load) fetch_addr_reg <= o_pc_addr;
      if (state_reg == ST_RUN && state_next == ST_HOLD) begin
        hold_instr_reg <= i_pc_instruction;
        hold_addr_reg  <= i_pc_addr;
      end
      if (state_reg == ST_HALTED) begin
        if (i_branch) resume_addr_reg <= i_branch_addr;
      end else if (state_next == ST_HALTED) begin
        resume_addr_reg <= halt_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program_counter model
// (registered fetch: address/instruction appear one cycle after the PC value).
module tb_fetch_sequencer;

  localparam int         AW = 8;
  localparam logic [7:0] RV = 8'h10;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_pc_instruction;
  logic [7:0]  i_pc_addr;
  logic        o_pc_inc;
  logic        o_pc_load;
  logic [7:0]  o_pc_addr;
  logic [15:0] o_instruction;
  logic [7:0]  o_instr_addr;
  logic        o_instr_valid;
  logic        i_ready;
  logic        i_branch;
  logic [7:0]  i_branch_addr;
  logic        i_halt;
  logic        i_run;
  logic        o_halted;
  logic [15:0] o_retired_count;

  int asserts  = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pc_instruction(i_pc_instruction), .i_pc_addr(i_pc_addr),
    .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load), .o_pc_addr(o_pc_addr),
    .o_instruction(o_instruction), .o_instr_addr(o_instr_addr),
    .o_instr_valid(o_instr_valid), .i_ready(i_ready),
    .i_branch(i_branch), .i_branch_addr(i_branch_addr),
    .i_halt(i_halt), .i_run(i_run),
    .o_halted(o_halted), .o_retired_count(o_retired_count)
  );

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Program counter model
  logic [7:0] pc_q = 8'h00;
  initial begin
    i_pc_addr        = 8'h00;
    i_pc_instruction = 16'h0000;
  end
  always @(posedge i_clk) begin
    if (o_pc_load)     pc_q <= o_pc_addr;
    else if (o_pc_inc) pc_q <= pc_q + 8'd1;
    i_pc_addr        <= pc_q;
    i_pc_instruction <= instr_of(pc_q);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ld, inc, input logic [7:0] pa,
                            input logic v, input logic [7:0] a, input logic h,
                            input logic [15:0] cnt);
    check({tag, "/load"}, {31'd0, o_pc_load}, {31'd0, ld});
    check({tag, "/inc"}, {31'd0, o_pc_inc}, {31'd0, inc});
    if (ld) check({tag, "/pc_addr"}, {24'd0, o_pc_addr}, {24'd0, pa});
    check({tag, "/valid"}, {31'd0, o_instr_valid}, {31'd0, v});
    if (v) begin
      check({tag, "/addr"}, {24'd0, o_instr_addr}, {24'd0, a});
      check({tag, "/instr"}, {16'd0, o_instruction}, {16'd0, instr_of(a)});
    end
    check({tag, "/halted"}, {31'd0, o_halted}, {31'd0, h});
    check({tag, "/count"}, {16'd0, o_retired_count}, {16'd0, cnt});
  endtask

  task automatic drive(input logic rdy, br, input logic [7:0] ba, input logic hl, rn);
    @(negedge i_clk);
    i_ready       = rdy;
    i_branch      = br;
    i_branch_addr = ba;
    i_halt        = hl;
    i_run         = rn;
    #1;
  endtask

  task automatic step(input string tag, input logic rdy, br, input logic [7:0] ba,
                      input logic hl, rn, ld, inc, input logic [7:0] pa,
                      input logic v, input logic [7:0] a, input logic h,
                      input logic [15:0] cnt);
    drive(rdy, br, ba, hl, rn);
    check_outs(tag, ld, inc, pa, v, a, h, cnt);
    $display("%-10s valid=%0d addr=%02h load=%0d pc_addr=%02h halted=%0d count=%0d",
             tag, o_instr_valid, o_instr_addr, o_pc_load, o_pc_addr, o_halted, o_retired_count);
  endtask

  initial begin
    i_reset = 1'b1;
    i_ready = 1'b1; i_branch = 1'b0; i_branch_addr = 8'h00; i_halt = 1'b0; i_run = 1'b0;
    @(negedge i_clk); @(negedge i_clk); #1;
    check_outs("reset", 1, 0, RV, 0, 8'h00, 0, 16'd0);
    i_reset = 1'b0; #1;
    check_outs("boot", 1, 0, RV, 0, 8'h00, 0, 16'd0);

    //        tag          rdy br ba     hl rn ld inc pa     v  a      h  cnt
    step("bubble0",    1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd0);
    step("run10",      1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h10, 0, 16'd0);
    step("run11",      1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h11, 0, 16'd1);
    step("run12",      1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h12, 0, 16'd2);
    step("stall13a",   0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h13, 0, 16'd3);
    step("stall13b",   0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h13, 0, 16'd3);
    step("stall13c",   0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h13, 0, 16'd3);
    step("release13",  1, 0, 8'h00, 0, 0, 1, 0, 8'h14, 1, 8'h13, 0, 16'd3);
    step("bubble14",   1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd4);
    step("run14",      1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h14, 0, 16'd4);
    step("branch15",   1, 1, 8'h40, 0, 0, 1, 0, 8'h40, 1, 8'h15, 0, 16'd5);
    step("bubble40",   1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd5);
    step("halt40",     1, 0, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h40, 0, 16'd5);
    step("halted",     1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 16'd6);
    step("hbranch30",  1, 1, 8'h30, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 16'd6);
    step("run30",      1, 0, 8'h00, 0, 1, 1, 0, 8'h30, 0, 8'h00, 1, 16'd6);
    step("bubble30",   1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd6);
    step("halt30",     0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h30, 0, 16'd6);
    step("halted2",    1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 16'd6);
    step("haltrun",    1, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00, 1, 16'd6);
    step("resume30",   1, 0, 8'h00, 0, 1, 1, 0, 8'h30, 0, 8'h00, 1, 16'd6);
    step("bubble30b",  0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd6);
    step("hold30a",    0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h30, 0, 16'd6);
    step("hold30b",    0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h30, 0, 16'd6);

    // Asynchronous reset in the middle of a HOLD cycle
    @(posedge i_clk); #2;
    i_reset = 1'b1; #1;
    check_outs("async_rst", 1, 0, RV, 0, 8'h00, 0, 16'd0);
    $display("async_rst  valid=%0d load=%0d pc_addr=%02h count=%0d",
             o_instr_valid, o_pc_load, o_pc_addr, o_retired_count);
    @(negedge i_clk); #1;
    i_ready = 1'b1;
    i_reset = 1'b0; #1;
    check_outs("reboot", 1, 0, RV, 0, 8'h00, 0, 16'd0);
    step("rebubble",   1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'd0);

    // Free-run with ready high: address wrap and counter wrap
    for (int i = 0; i <= 32'h10000; i++) begin
      drive(1, 0, 8'h00, 0, 0);
      if (i == 0) check_outs("restart10", 0, 1, 8'h00, 1, 8'h10, 0, 16'd0);
      if (i == 32'hEF) check_outs("addr_ff", 0, 1, 8'h00, 1, 8'hFF, 0, 16'hEF);
      if (i == 32'hF0) check_outs("addr_wrap", 0, 1, 8'h00, 1, 8'h00, 0, 16'hF0);
      if (i == 32'hFFFF) begin
        check("count_ffff", {16'd0, o_retired_count}, 32'h0000FFFF);
        $display("count_ffff count=%0h", o_retired_count);
      end
      if (i == 32'h10000) begin
        check("count_wrap", {16'd0, o_retired_count}, 32'h00000000);
        $display("count_wrap count=%0h", o_retired_count);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
